// File: rtl/mem_pkg.sv
// mem_pkg: access-size encoding, cache FSM states and byte-lane mask shared by the data-side memory blocks.
package mem_pkg;
  typedef logic [1:0] rw_type;
  localparam rw_type RW_B = 2'b00;
  localparam rw_type RW_H = 2'b01;
  localparam rw_type RW_W = 2'b10;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} dc_state;
  function automatic logic [3:0] byte_mask(rw_type t, logic [1:0] off);
    return t == RW_B ? 4'b0001 << off : t == RW_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/dcache_extract.sv
// dcache_extract: byte/half selection from a word with sign or zero extension.
module dcache_extract
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  rw_type      typ,
  input  logic        sign_ext,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{off, 3'b000} +: 8];
  assign h = off[1] ? word[31:16] : word[15:0];
  assign data = typ == RW_B ? {{24{sign_ext & b[7]}}, b}
              : typ == RW_H ? {{16{sign_ext & h[15]}}, h} : word;
endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped one-word-line write-through, no-write-allocate data cache.
module dcache_wt
  import mem_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  rw_type      cpu_type,
  input  logic        cpu_sign_ext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output rw_type      mem_type,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  dc_state state, state_n;
  logic [31:0]   data_q [SETS];
  logic [TW-1:0] tag_q [SETS];
  logic [SETS-1:0] valid_q;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [31:0]   ext, wrep;
  logic [3:0]    wmask;
  logic          hit, bad, fill, merge, flush_now;
  assign idx = cpu_addr[IW+1:2];
  assign tag = cpu_addr[31:IW+2];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign bad = cpu_type == RW_H ? cpu_addr[0] : cpu_type == RW_W ? |cpu_addr[1:0] : cpu_type != RW_B;
  assign misaligned = cpu_req && bad;
  assign fill = state == RD_MISS && mem_ready;
  assign merge = state == WR_THRU && mem_ready && hit;
  // Flush during a transaction waits for its completing edge so the fill cannot revalidate the line.
  assign flush_now = cpu_flush && (state == IDLE || mem_ready);
  assign wmask = byte_mask(cpu_type, cpu_addr[1:0]);
  assign wrep = cpu_type == RW_B ? {4{cpu_wdata[7:0]}} : cpu_type == RW_H ? {2{cpu_wdata[15:0]}} : cpu_wdata;
  dcache_extract u_extract (
    .word(data_q[idx]), .off(cpu_addr[1:0]), .typ(cpu_type), .sign_ext(cpu_sign_ext), .data(ext)
  );
  always_comb begin
    state_n = state;
    stall = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = cpu_addr;
    mem_type = cpu_type;
    mem_wdata = cpu_wdata;
    cpu_rdata = '0;
    if (state == IDLE) begin
      if (cpu_flush) stall = 1'b1;
      else if (cpu_req && !bad) begin
        stall = cpu_we || !hit;
        state_n = cpu_we ? WR_THRU : hit ? IDLE : RD_MISS;
        cpu_rdata = (!cpu_we && hit) ? ext : '0;
      end
    end else begin
      mem_req = 1'b1;
      mem_we = state == WR_THRU;
      mem_addr = state == RD_MISS ? {cpu_addr[31:2], 2'b00} : cpu_addr;
      mem_type = state == RD_MISS ? RW_W : cpu_type;
      stall = state == RD_MISS || !mem_ready;
      state_n = mem_ready ? IDLE : state;
    end
    if (rst) begin
      stall = 1'b0;
      mem_req = 1'b0;
      mem_we = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      valid_q <= '0;
    end else begin
      state <= state_n;
      if (flush_now) valid_q <= '0;
      else if (fill) valid_q[idx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx] <= tag;
    end else if (merge)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) data_q[idx][8*i +: 8] <= wrep[8*i +: 8];
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed sequence with read-data and memory-transaction scoreboards.
module tb_dcache_wt;
  import mem_pkg::*;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, cpu_sign_ext = 0, cpu_flush = 0;
  logic [1:0] cpu_type = RW_W;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic stall, misaligned, mem_req, mem_we;
  logic mem_ready = 0;
  logic [1:0] mem_type;
  int checks = 0, errors = 0, mem_cnt = 0;
  bit auto_mem = 1;
  logic [31:0] rd_q[$];
  logic [66:0] mem_q[$];
  logic [31:0] model[logic [31:0]];
  logic [66:0] me;
  logic [31:0] wa, wv;
  logic [3:0] wm;

  dcache_wt #(.SETS(64)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type),
    .cpu_sign_ext(cpu_sign_ext), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush),
    .cpu_rdata(cpu_rdata), .stall(stall), .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Zero-latency memory: answers each request at the negedge of its first cycle.
  always @(negedge clk)
    if (auto_mem) begin
      if (mem_ready) mem_ready = 0;
      else if (mem_req) begin
        mem_cnt++;
        chk("mem_expected", 64'(mem_q.size() != 0), 64'd1);
        if (mem_q.size() != 0) begin
          me = mem_q.pop_front();
          chk("mem_txn", {29'b0, mem_we, mem_type, mem_addr}, {29'b0, me[66:32]});
          if (me[66]) chk("mem_wdata", 64'(mem_wdata), 64'(me[31:0]));
        end
        wa = {mem_addr[31:2], 2'b00};
        wv = model.exists(wa) ? model[wa] : 32'h0;
        if (mem_we) begin
          wm = mem_type == RW_B ? 4'b0001 << mem_addr[1:0] : mem_type == RW_H ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          for (int i = 0; i < 4; i++)
            if (wm[i]) wv[8*i +: 8] = mem_type == RW_B ? mem_wdata[7:0] : mem_type == RW_H ? mem_wdata[8*(i%2) +: 8] : mem_wdata[8*i +: 8];
          model[wa] = wv;
        end else mem_rdata = wv;
        mem_ready = 1;
      end
    end

  task automatic access(input string tag, input bit we, input logic [1:0] typ, input bit sx,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_stall,
                        input int exp_mem, input logic [31:0] exp_rd, input bit exp_mis);
    int stalls = 0;
    int m0 = mem_cnt;
    cpu_req = 1; cpu_we = we; cpu_type = typ; cpu_sign_ext = sx; cpu_addr = addr; cpu_wdata = wdata;
    rd_q.push_back(exp_rd);
    if (exp_mem != 0) mem_q.push_back({we, we ? typ : RW_W, we ? addr : {addr[31:2], 2'b00}, wdata});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!stall) break;
      stalls++;
    end
    chk({tag, "_rdata"}, 64'(cpu_rdata), 64'(rd_q.pop_front()));
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
    chk({tag, "_memreqs"}, 64'(mem_cnt - m0), 64'(exp_mem));
    chk({tag, "_misaligned"}, 64'(misaligned), 64'(exp_mis));
    @(posedge clk); #1;
    cpu_req = 0; cpu_we = 0;
  endtask

  initial begin
    model[32'h10000] = 32'hDEADBEEF;
    model[32'h10004] = 32'h80FF7F01;
    model[32'h10008] = 32'h11111111;
    model[32'h30000] = 32'hCAFEF00D;
    #12;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_rdata", 64'(cpu_rdata), 64'd0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    access("cold_load",  0, RW_W, 0, 32'h10000, 0, 2, 1, 32'hDEADBEEF, 0);
    access("hit_load",   0, RW_W, 0, 32'h10000, 0, 0, 0, 32'hDEADBEEF, 0);
    access("fill_1",     0, RW_W, 0, 32'h10004, 0, 2, 1, 32'h80FF7F01, 0);
    access("b_sx_off2",  0, RW_B, 1, 32'h10006, 0, 0, 0, 32'hFFFFFFFF, 0);
    access("b_off0",     0, RW_B, 1, 32'h10004, 0, 0, 0, 32'h00000001, 0);
    access("b_zx_off3",  0, RW_B, 0, 32'h10007, 0, 0, 0, 32'h00000080, 0);
    access("h_sx_off2",  0, RW_H, 1, 32'h10006, 0, 0, 0, 32'hFFFF80FF, 0);
    access("h_zx_off0",  0, RW_H, 0, 32'h10004, 0, 0, 0, 32'h00007F01, 0);
    access("st_b_hit",   1, RW_B, 0, 32'h10001, 32'h000000AA, 1, 1, 32'h0, 0);
    access("ld_merged",  0, RW_W, 0, 32'h10000, 0, 0, 0, 32'hDEADAAEF, 0);
    access("st_h_hit",   1, RW_H, 0, 32'h10006, 32'h0000BEEF, 1, 1, 32'h0, 0);
    access("ld_merged2", 0, RW_W, 0, 32'h10004, 0, 0, 0, 32'hBEEF7F01, 0);
    access("st_w_miss",  1, RW_W, 0, 32'h20000, 32'h12345678, 1, 1, 32'h0, 0);
    access("ld_after_st_miss", 0, RW_W, 0, 32'h20000, 0, 2, 1, 32'h12345678, 0);
    access("mis_half",   0, RW_H, 0, 32'h10001, 0, 0, 0, 32'h0, 1);
    access("mis_word",   0, RW_W, 0, 32'h10006, 0, 0, 0, 32'h0, 1);
    access("mis_type",   0, 2'b11, 0, 32'h10004, 0, 0, 0, 32'h0, 1);
    access("mis_store",  1, RW_H, 0, 32'h10003, 32'h5555, 0, 0, 32'h0, 1);
    @(negedge clk); #1;
    chk("idle_stall", 64'(stall), 64'd0);
    chk("idle_rdata", 64'(cpu_rdata), 64'd0);
    @(posedge clk); #1;
    auto_mem = 0;
    cpu_req = 1; cpu_we = 0; cpu_type = RW_W; cpu_addr = 32'h30000;
    @(negedge clk); #1 chk("abort_miss_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    chk("abort_mem_req", 64'(mem_req), 64'd1);
    chk("abort_mem_addr", 64'(mem_addr), 64'h30000);
    rst = 1; #1;
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_mem_req", 64'(mem_req), 64'd0);
    cpu_req = 0;
    @(posedge clk); #1 rst = 0; mem_ready = 1; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk); #1;
    chk("late_ready_stall", 64'(stall), 64'd0);
    chk("late_ready_mem_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1 mem_ready = 0; auto_mem = 1;
    access("after_rst_miss",  0, RW_W, 0, 32'h30000, 0, 2, 1, 32'hCAFEF00D, 0);
    access("rst_cleared_valid", 0, RW_W, 0, 32'h10004, 0, 2, 1, 32'hBEEF7F01, 0);
    access("fill_a", 0, RW_W, 0, 32'h10000, 0, 2, 1, 32'hDEADAAEF, 0);
    access("fill_b", 0, RW_W, 0, 32'h10008, 0, 2, 1, 32'h11111111, 0);
    access("hit_b",  0, RW_W, 0, 32'h10008, 0, 0, 0, 32'h11111111, 0);
    cpu_flush = 1;
    @(negedge clk); #1 chk("flush_stall", 64'(stall), 64'd1);
    @(posedge clk); #1 cpu_flush = 0;
    access("flushed_a", 0, RW_W, 0, 32'h10000, 0, 2, 1, 32'hDEADAAEF, 0);
    access("flushed_b", 0, RW_W, 0, 32'h10008, 0, 2, 1, 32'h11111111, 0);
    repeat (2) @(posedge clk);
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 Parameter: SETS, default 64, number of direct-mapped one-word lines (power of 2, at least 4).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cpu_req  input  1  access request from the MEM stage.
REQ-005 cpu_we  input  1  1 = store, 0 = load.
REQ-006 cpu_type  input  rw_type  access size: b, half or word.
REQ-007 cpu_sign_ext  input  1  sign-extend b/half loads.
REQ-008 cpu_addr  input  32  byte address.
REQ-009 cpu_wdata  input  32  store data, LSB-aligned.
REQ-010 cpu_flush  input  1  invalidate all lines.
REQ-011 cpu_rdata  output  32  load result, extended per cpu_type/cpu_sign_ext.
REQ-012 stall  output  1  holds the pipeline while the access is not complete.
REQ-013 misaligned  output  1  half at odd address or word at address not 4-aligned.
REQ-014 mem_req, mem_we  output  1 each  downstream request and its direction.
REQ-015 mem_addr  output  32;  mem_wdata  output  32;  mem_type  output  rw_type.
REQ-016 mem_ready  input  1;  mem_rdata  input  32  (downstream completion and read word).

Function
REQ-017 Address split: index = cpu_addr[2+log2(SETS)-1:2]; tag = remaining upper bits; byte offset = cpu_addr[1:0].
REQ-018 FSM states: IDLE, RD_MISS, WR_THRU.
REQ-019 IDLE load hit (valid and tag match): cpu_rdata valid combinationally in the same cycle; stall=0; no mem_req.
REQ-020 IDLE load miss: stall=1 combinationally; next state RD_MISS.
REQ-021 RD_MISS: mem_req=1, mem_we=0, mem_type=word, mem_addr={cpu_addr[31:2],2'b00}; stall=1.
REQ-022 RD_MISS with mem_ready=1: write mem_rdata, tag and valid=1 into the line; return to IDLE.
REQ-023 After a miss fill, the retried access hits; the minimum miss cost is 2 stalled cycles.
REQ-024 IDLE store: stall=1; next state WR_THRU (write-through).
REQ-025 WR_THRU: mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_type=cpu_type, mem_wdata=cpu_wdata; stall=1 until mem_ready.
REQ-026 On mem_ready in WR_THRU:
- hit: merge only the addressed bytes into the line;
- miss: no allocate, no line change;
- stall drops in that same cycle and the FSM returns to IDLE.
REQ-027 Load extraction:
- b selects byte [offset];
- half selects the halfword at [offset[1]];
- upper bits are zero, or sign if cpu_sign_ext=1 (sign_ext ignored for word).
REQ-028 misaligned=1 in IDLE with cpu_req: no mem_req, no state change, stall=0, cpu_rdata=0.
REQ-029 cpu_type outside {b, half, word}: treated as misaligned.
REQ-030 cpu_req=0 in IDLE: stall=0, mem_req=0, cpu_rdata=0.
REQ-031 cpu_flush in IDLE: clears all valid bits at the edge and stalls for that cycle; any cpu_req that cycle is ignored and retried.
REQ-032 cpu_flush during RD_MISS/WR_THRU: applied at the completing edge, after the fill or merge (the filled line ends invalid).
REQ-033 mem_req, mem_addr, mem_we, mem_type and mem_wdata stay stable until mem_ready; cpu_* inputs stay stable while stall=1.

Reset
REQ-034 rst asserted: state=IDLE and all valid bits=0 immediately; stall, mem_req and mem_we deassert asynchronously.
REQ-035 rst mid-miss or mid-write: the transaction is abandoned; a late mem_ready after reset is ignored in IDLE.
REQ-036 Data and tag arrays are not reset.

Structure
REQ-037 rw_type (b=00, half=01, word=10) lives in shared package mem_pkg, used by this block and the data memory.
REQ-038 Sub-module dcache_extract: combinational byte/half selection and sign/zero extension, reusable by the memory stage.

Verification
REQ-039 Cold load word 0x10000, memory holds 0xDEADBEEF -> stall high 2 cycles, one read mem_req, then cpu_rdata=0xDEADBEEF; repeat load -> stall=0, no mem_req.
REQ-040 Line holds 0x80FF7F01: load b, sign_ext=1 at offset 2 -> 0xFFFFFFFF; b offset 0 -> 0x00000001; half, sign_ext=1 at offset 2 -> 0xFFFF80FF.
REQ-041 Store b 0xAA to cached 0x10001 -> WR_THRU with mem_type=b; line becomes 0xDEADAAEF; store to uncached 0x20000 -> no fill, next load misses.
REQ-042 Load half at 0x10001 -> misaligned=1, stall=0, no mem_req.
REQ-043 rst pulsed in RD_MISS before mem_ready, then mem_ready given -> FSM stays IDLE; next load to the same address misses.
REQ-044 cpu_flush after two fills -> both following loads miss.
